seg_scan_display: RTL and testbench

Eight-digit seven-segment display controller sitting directly downstream of the pipelined CPU's LED and statistics outputs on the board top level. It consumes the CPU's syscall LED word and its four 32-bit performance counters, selects one source with a debounced mode button, and snapshots it once per scan frame so digits never tear. It time-multiplexes the eight hex digits onto active-low anode/segment pins.

---
 rtl/seg_scan_display.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment display controller.
// A debounced mode button picks one of five 32-bit CPU sources. The selected
// value is snapshotted once per scan frame so a frame never mixes two values.
// Anodes and segments are active-low and are registered together.
module seg_scan_display #(
    parameter int SCAN_BITS  = 17,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] led_data_in,
    input  logic [31:0] total_cycles,
    input  logic [31:0] condi_branch_num,
    input  logic [31:0] uncondi_branch_num,
    input  logic [31:0] bubble_num,
    input  logic        mode_btn,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [2:0]  mode
);

    localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 1);

    // Button synchronizer, sync-valid pipeline and debouncer state
    logic        sync1_q, sync2_q;
    logic        vld1_q, vld2_q;
    logic        armed_q, armed_d;
    logic        stable_q, stable_d;
    logic        stable_prev_q;
    logic [23:0] cnt_q, cnt_d;
    logic        step;

    // Scan state
    logic [SCAN_BITS-1:0] prescaler_q, prescaler_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           mode_q, mode_d;
    logic [2:0]           mode_step;
    logic [31:0]          disp_val_q, disp_val_d;
    logic                 tick;

    // Output registers
    logic [7:0] an_q, an_d;
    logic [7:0] seg_q, seg_d;

    // Source table indexed by mode; unreachable codes read as zero
    logic [31:0] src_tab [8];
    assign src_tab[0] = led_data_in;
    assign src_tab[1] = total_cycles;
    assign src_tab[2] = condi_branch_num;
    assign src_tab[3] = uncondi_branch_num;
    assign src_tab[4] = bubble_num;
    generate
        for (genvar gi = 5; gi < 8; gi++) begin : g_unused_src
            assign src_tab[gi] = 32'h0;
        end
    endgenerate

    // Nibble per digit of the frozen display value
    logic [3:0] nib [8];
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_nib
            assign nib[gi] = disp_val_q[4*gi +: 4];
        end
    endgenerate

    // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hexfont(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0: f = 7'h40;
            4'h1: f = 7'h79;
            4'h2: f = 7'h24;
            4'h3: f = 7'h30;
            4'h4: f = 7'h19;
            4'h5: f = 7'h12;
            4'h6: f = 7'h02;
            4'h7: f = 7'h78;
            4'h8: f = 7'h00;
            4'h9: f = 7'h10;
            4'hA: f = 7'h08;
            4'hB: f = 7'h03;
            4'hC: f = 7'h46;
            4'hD: f = 7'h21;
            4'hE: f = 7'h06;
            default: f = 7'h0E;
        endcase
        return f;
    endfunction

    // Two-flop synchronizer plus a valid pipeline so we know when sync2 reflects
    // the real pin rather than its reset value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
        end else begin
            sync1_q <= mode_btn;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
        end
    end

    // Debouncer: accept a new level after DEB_CYCLES consecutive mismatching clocks.
    // Stepping is armed only once a released button has been seen after reset,
    // so a button held through reset cannot produce a step.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q | (vld2_q & ~sync2_q);
        if (sync2_q == stable_q) begin
            cnt_d = 24'd0;
        end else if (cnt_q == DEB_LAST) begin
            stable_d = sync2_q;
            cnt_d    = 24'd0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // Debouncer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= 24'd0;
            armed_q       <= 1'b0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
        end
    end

    assign step      = armed_q & stable_q & ~stable_prev_q;
    assign tick      = &prescaler_q;
    assign mode_step = (mode_q == 3'd4) ? 3'd0 : mode_q + 3'd1;

    // Scan next state: a step restarts the frame on the new source and wins over tick
    always_comb begin
        mode_d      = mode_q;
        prescaler_d = prescaler_q + SCAN_BITS'(1);
        idx_d       = idx_q;
        disp_val_d  = disp_val_q;
        if (step) begin
            mode_d      = mode_step;
            prescaler_d = '0;
            idx_d       = 3'd0;
            disp_val_d  = src_tab[mode_step];
        end else if (tick) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                disp_val_d = src_tab[mode_q];
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 3'd0;
            prescaler_q <= '0;
            idx_q       <= 3'd0;
            disp_val_q  <= 32'h0;
        end else begin
            mode_q      <= mode_d;
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            disp_val_q  <= disp_val_d;
        end
    end

    // Anode/segment pair for the current digit; decimal point marks digit == mode
    always_comb begin
        an_d  = ~(8'b1 << idx_q);
        seg_d = {(idx_q == mode_q) ? 1'b0 : 1'b1, hexfont(nib[idx_q])};
    end

    // Output registers, anode and segments updated on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_BITS=2, DEB_CYCLES=4.
// Outputs are sampled 1 ns after the rising edge; edge counts are from reset release.
module tb_seg_scan_display;

    logic        clk;
    logic        rst;
    logic [31:0] led_data_in;
    logic [31:0] total_cycles;
    logic [31:0] condi_branch_num;
    logic [31:0] uncondi_branch_num;
    logic [31:0] bubble_num;
    logic        mode_btn;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [2:0]  mode;

    int checks = 0;
    int errors = 0;

    seg_scan_display #(
        .SCAN_BITS (2),
        .DEB_CYCLES(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .led_data_in       (led_data_in),
        .total_cycles      (total_cycles),
        .condi_branch_num  (condi_branch_num),
        .uncondi_branch_num(uncondi_branch_num),
        .bubble_num        (bubble_num),
        .mode_btn          (mode_btn),
        .an                (an),
        .seg               (seg),
        .mode              (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame 1 shows 32'h1234_5678: digit i carries nibble 8-i; digit 0 has dp lit
    logic [7:0] f1_seg [8] = '{8'h00, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

    // Press table: expected mode, digit 0 seg, digit 1 seg after each press
    logic [2:0] pr_mode [7] = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0] pr_seg0 [7] = '{8'hA4, 8'hB0, 8'h99, 8'h0E, 8'h8E, 8'hA4, 8'hB0};
    logic [7:0] pr_seg1 [7] = '{8'hC6, 8'hA1, 8'h83, 8'h8E, 8'h0E, 8'hC6, 8'hA1};

    initial begin
        logic [7:0] exp_seg;
        rst                = 1'b0;
        mode_btn           = 1'b0;
        led_data_in        = 32'h1234_5678;
        total_cycles       = 32'h0000_00A1;
        condi_branch_num   = 32'h0000_00C2;
        uncondi_branch_num = 32'h0000_00D3;
        bubble_num         = 32'h0000_00B4;
        #1 rst = 1'b1;
        adv(2);
        check_val("reset_an", {24'h0, an}, 32'hFF);
        check_val("reset_seg", {24'h0, seg}, 32'hFF);
        check_val("reset_mode", {29'h0, mode}, 32'h0);
        rst = 1'b0;

        // Three frames: zero value, 1234_5678, then all-F after a mid-frame change
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                adv((f == 0 && i == 0) ? 1 : 4);
                if (f == 0)      exp_seg = (i == 0) ? 8'h40 : 8'hC0;
                else if (f == 1) exp_seg = f1_seg[i];
                else             exp_seg = (i == 0) ? 8'h0E : 8'h8E;
                check_val($sformatf("scan_an_f%0d_d%0d", f, i), {24'h0, an}, {24'h0, ~(8'h01 << i)});
                check_val($sformatf("scan_seg_f%0d_d%0d", f, i), {24'h0, seg}, {24'h0, exp_seg});
                $display("frame %0d digit %0d an=%h seg=%h", f, i, an, seg);
                if (f == 1 && i == 3) led_data_in = 32'hFFFF_FFFF;
            end
        end

        // Glitch of 3 clocks: no step
        mode_btn = 1'b1;
        adv(3);
        mode_btn = 1'b0;
        adv(12);
        check_val("glitch_mode", {29'h0, mode}, 32'h0);
        $display("glitch press mode=%0d", mode);

        // Long press: step lands 7 edges after the button rises
        mode_btn = 1'b1;
        adv(6);
        check_val("step_early_mode", {29'h0, mode}, 32'h0);
        adv(1);
        check_val("step_mode", {29'h0, mode}, 32'h1);
        total_cycles = 32'hFFFF_FFFF;
        adv(1);
        check_val("step_an0", {24'h0, an}, 32'hFE);
        check_val("step_seg0", {24'h0, seg}, 32'hF9);
        adv(3);
        check_val("step_dwell_an0", {24'h0, an}, 32'hFE);
        adv(1);
        check_val("step_an1", {24'h0, an}, 32'hFD);
        check_val("step_seg1_dp", {24'h0, seg}, 32'h08);
        mode_btn = 1'b0;
        adv(20);
        check_val("hold_one_step", {29'h0, mode}, 32'h1);
        $display("long press mode=%0d", mode);

        // Seven further presses walk the mode through the wrap to 3
        for (int p = 0; p < 7; p++) begin
            mode_btn = 1'b1;
            adv(10);
            check_val($sformatf("press%0d_mode", p), {29'h0, mode}, {29'h0, pr_mode[p]});
            check_val($sformatf("press%0d_an0", p), {24'h0, an}, 32'hFE);
            check_val($sformatf("press%0d_seg0", p), {24'h0, seg}, {24'h0, pr_seg0[p]});
            mode_btn = 1'b0;
            adv(4);
            check_val($sformatf("press%0d_an1", p), {24'h0, an}, 32'hFD);
            check_val($sformatf("press%0d_seg1", p), {24'h0, seg}, {24'h0, pr_seg1[p]});
            $display("press %0d mode=%0d seg0=%h seg1=%h", p, mode, pr_seg0[p], seg);
            adv(6);
        end

        // Mid-frame reset at mode 3, digit 5, with the button held across it
        adv(8);
        check_val("pre_rst_an5", {24'h0, an}, 32'hDF);
        check_val("pre_rst_mode", {29'h0, mode}, 32'h3);
        mode_btn = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_an", {24'h0, an}, 32'hFF);
        check_val("async_rst_seg", {24'h0, seg}, 32'hFF);
        check_val("async_rst_mode", {29'h0, mode}, 32'h0);
        adv(2);
        rst = 1'b0;
        adv(1);
        check_val("post_rst_an", {24'h0, an}, 32'hFE);
        check_val("post_rst_seg", {24'h0, seg}, 32'h40);
        adv(20);
        check_val("held_through_rst", {29'h0, mode}, 32'h0);
        mode_btn = 1'b0;
        adv(10);
        mode_btn = 1'b1;
        adv(10);
        check_val("repress_mode", {29'h0, mode}, 32'h1);
        $display("reset and re-press mode=%0d", mode);
        mode_btn = 1'b0;
        adv(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
